// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage core: load-use bubbles, taken-branch
// flushes, data-memory freeze with timeout into HALT, and saturating
// stall/flush performance counters. Control outputs are combinational so
// they act in the same cycle; state and counters update on clk.
module hazard_stall_controller #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             uses_rs1_ID,
    input  logic             uses_rs2_ID,
    input  logic [4:0]       rd_EX,
    input  logic             mem_read_EX,
    input  logic             branch_taken_EX,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        st_run      = 2'd0,
        st_mem_wait = 2'd1,
        st_halt     = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WCW-1:0]     wait_cnt_reg, wait_cnt_next, wait_cnt_inc;
    logic [CNT_W-1:0]   stall_cycles_reg, flush_count_reg;
    logic               stall_inc, flush_inc;
    logic               mem_wait, load_use, rs1_hit, rs2_hit;

    // Hazard detection: memory not ready, and a load whose result the ID
    // instruction needs before forwarding can supply it.
    assign mem_wait     = dmem_req && !dmem_ready;
    assign rs1_hit      = uses_rs1_ID && (rs1_ID == rd_EX);
    assign rs2_hit      = uses_rs2_ID && (rs2_ID == rd_EX);
    assign load_use     = mem_read_EX && (rd_EX != 5'd0) && (rs1_hit || rs2_hit);
    assign wait_cnt_inc = wait_cnt_reg + WCW'(1);

    // Prioritised control outputs plus next-state and counter-increment decisions.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        mem_timeout   = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (!arst_n) begin
            // Held in reset: freeze everything and inject bubbles.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (state_reg == st_halt) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
            mem_timeout   = 1'b1;
        end else if (mem_wait) begin
            // Freeze everything up to MEM; a branch in EX waits with it.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            stall_inc     = 1'b1;
            if (state_reg == st_run) begin
                state_next    = st_mem_wait;
                wait_cnt_next = WCW'(1);
            end else if (wait_cnt_inc == WCW'(WAIT_TIMEOUT)) begin
                state_next    = st_halt;
                wait_cnt_next = wait_cnt_inc;
            end else begin
                wait_cnt_next = wait_cnt_inc;
            end
        end else begin
            // Memory ready or idle: leave any wait (also recovers an illegal encoding).
            if (state_reg != st_run) begin
                state_next    = st_run;
                wait_cnt_next = '0;
            end
            if (branch_taken_EX) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_inc   = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                stall_inc   = 1'b1;
            end
        end
    end

    // State, wait counter and saturating performance counters.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_reg        <= st_run;
            wait_cnt_reg     <= '0;
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (stall_inc && (stall_cycles_reg != {CNT_W{1'b1}}))
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            if (flush_inc && (flush_count_reg != {CNT_W{1'b1}}))
                flush_count_reg <= flush_count_reg + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios followed by random
// traffic, all compared each cycle against a rule-level reference model.
module tb_hazard_stall_controller;

    localparam int WT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          arst_n;
    logic [4:0]    rs1_ID, rs2_ID, rd_EX;
    logic          uses_rs1_ID, uses_rs2_ID, mem_read_EX, branch_taken_EX;
    logic          dmem_req, dmem_ready;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic          if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: consecutive not-ready cycles, halted flag, counters.
    bit m_valid  = 1'b0;
    bit m_halted = 1'b0;
    int m_nr     = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
        .clk(clk), .arst_n(arst_n),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
        .rd_EX(rd_EX), .mem_read_EX(mem_read_EX),
        .branch_taken_EX(branch_taken_EX),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
        .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit model_load_use();
        return mem_read_EX && (rd_EX != 5'd0) &&
               ((uses_rs1_ID && rs1_ID == rd_EX) || (uses_rs2_ID && rs2_ID == rd_EX));
    endfunction

    // Expected {pc,if_id,id_ex,ex_mem enables, if_id_flush, id_ex_flush, bubble, timeout}.
    function automatic logic [7:0] model_ctrl();
        if (!arst_n)                  return 8'b0000_1110;
        if (m_halted)                 return 8'b0000_1111;
        if (dmem_req && !dmem_ready)  return 8'b0000_0010;
        if (branch_taken_EX)          return 8'b1111_1100;
        if (model_load_use())         return 8'b0011_0100;
        return 8'b1111_0000;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // One clock of stimulus: drive, check at negedge, advance model at posedge.
    task automatic cycle_drive(input logic rst_n_v, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic u1, input logic u2,
                               input logic mr, input logic br, input logic rq, input logic rdy);
        logic [7:0] outv;
        arst_n = rst_n_v; rs1_ID = r1; rs2_ID = r2; rd_EX = rd;
        uses_rs1_ID = u1; uses_rs2_ID = u2; mem_read_EX = mr;
        branch_taken_EX = br; dmem_req = rq; dmem_ready = rdy;
        @(negedge clk);
        outv = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout};
        check_eq("ctrl", {24'd0, outv}, {24'd0, model_ctrl()});
        if (m_valid) begin
            check_eq("stall_cycles", {{(32-CW){1'b0}}, stall_cycles}, 32'(m_stall));
            check_eq("flush_count", {{(32-CW){1'b0}}, flush_count}, 32'(m_flush));
        end
        $display("cyc %0d rst_n=%b req=%b rdy=%b br=%b lu=%b ctrl=%b stall=%0d flush=%0d",
                 cyc, rst_n_v, rq, rdy, br, model_load_use(), outv, stall_cycles, flush_count);
        @(posedge clk);
        if (!rst_n_v) begin
            m_valid = 1'b1; m_halted = 1'b0; m_nr = 0; m_stall = 0; m_flush = 0;
        end else if (!m_halted) begin
            if (rq && !rdy) begin
                m_nr++;
                m_stall = sat_inc(m_stall);
                if (m_nr == WT) m_halted = 1'b1;
            end else begin
                m_nr = 0;
                if (br)                     m_flush = sat_inc(m_flush);
                else if (model_load_use())  m_stall = sat_inc(m_stall);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input logic rst_n_v);
        cycle_drive(rst_n_v, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);

        // Load-use on rs1, then same pattern with rd_EX=0 (no hazard)
        cycle_drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        cycle_drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Load-use via rs2 only; rs1 match but unused
        cycle_drive(1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle_drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Branch overrides load-use
        cycle_drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);

        // Memory wait 3 cycles with branch held, then ready; dmem_req with ready is no stall
        for (int i = 0; i < 3; i++)
            cycle_drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle_drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle_drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Timeout into HALT; stays after ready until reset
        for (int i = 0; i < WT + 2; i++)
            cycle_drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle_drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);

        // Three-cycle wait stays below the timeout, then returns to RUN
        for (int i = 0; i < WT - 1; i++)
            cycle_drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);

        // Reset on the 2nd wait cycle
        cycle_drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle_drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle_drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Stall counter saturation: 20 load-use stalls
        for (int i = 0; i < 20; i++)
            cycle_drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Flush counter saturation
        for (int i = 0; i < 18; i++)
            cycle_drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Random traffic with small register indices to provoke matches
        for (int i = 0; i < 600; i++) begin
            cycle_drive(($urandom_range(0, 39) != 0),
                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) >= 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
